// File: rtl/aes_pkg.sv
// Shared address map, status bit positions and sequencer state encoding for
// the AES decryption register block.
package aes_pkg;

  localparam int ADDR_KEY0     = 0;
  localparam int ADDR_MSG_ENC0 = 4;
  localparam int ADDR_MSG_DEC0 = 8;
  localparam int ADDR_CTRL     = 14;
  localparam int ADDR_STATUS   = 15;

  localparam int STAT_DONE      = 0;
  localparam int STAT_TIMEOUT   = 1;
  localparam int STAT_STATE_LSB = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_if_state_t;

endpackage

// File: rtl/aes_byte_en_reg.sv
// 32-bit register with per-byte write enables; protect blocks writes so a word
// can be frozen while the core is consuming it.
module aes_byte_en_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic        protect,
  input  logic [3:0]  byte_en,
  input  logic [31:0] wdata,
  output logic [31:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (wr_en && !protect) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) q[8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/aes_avalon_regs.sv
// Avalon-MM register file in front of the AES decryption core: holds key and
// ciphertext, runs the start/done handshake and captures the plaintext.
module aes_avalon_regs
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         AVL_CS,
  input  logic         AVL_READ,
  input  logic         AVL_WRITE,
  input  logic [3:0]   AVL_ADDR,
  input  logic [3:0]   AVL_BYTE_EN,
  input  logic [31:0]  AVL_WRITEDATA,
  output logic [31:0]  AVL_READDATA,
  output logic [127:0] AES_KEY,
  output logic [127:0] AES_MSG_ENC,
  output logic         AES_START,
  input  logic         AES_DONE,
  input  logic [127:0] AES_MSG_DEC,
  output logic [31:0]  EXPORT_DATA
);

  localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] CNT_LAST = 32'(TIMEOUT_CYCLES - 1);

  aes_if_state_t state, state_next;
  logic [31:0]   regs [16];
  logic [31:0]   status;
  logic [31:0]   run_cnt;
  logic          ctrl_start, done_flag, timeout_flag;
  logic          bus_wr, ctrl_wr, go, stop, cnt_hit, capture, timed_out;

  assign bus_wr  = AVL_CS & AVL_WRITE;
  assign ctrl_wr = bus_wr && (AVL_ADDR == 4'(ADDR_CTRL)) && AVL_BYTE_EN[0];
  assign go      = ctrl_wr & AVL_WRITEDATA[0];
  assign stop    = ctrl_wr & ~AVL_WRITEDATA[0];
  assign cnt_hit = TO_EN && (run_cnt == CNT_LAST);

  // Words 8-11 are loaded only by the core; 0-7 freeze once a run has started.
  for (genvar i = 0; i < ADDR_CTRL; i++) begin : g_word
    if (i >= ADDR_MSG_DEC0 && i < ADDR_MSG_DEC0 + 4) begin : g_pt
      aes_byte_en_reg u_reg (
        .clk     (CLK),
        .reset   (RESET),
        .wr_en   (capture),
        .protect (1'b0),
        .byte_en (4'hF),
        .wdata   (AES_MSG_DEC[127 - 32*(i - ADDR_MSG_DEC0) -: 32]),
        .q       (regs[i])
      );
    end else begin : g_rw
      aes_byte_en_reg u_reg (
        .clk     (CLK),
        .reset   (RESET),
        .wr_en   (bus_wr && (AVL_ADDR == 4'(i))),
        .protect ((i < ADDR_MSG_DEC0) && (state != IDLE)),
        .byte_en (AVL_BYTE_EN),
        .wdata   (AVL_WRITEDATA),
        .q       (regs[i])
      );
    end
  end

  always_comb begin
    status                         = '0;
    status[STAT_DONE]              = done_flag;
    status[STAT_TIMEOUT]           = timeout_flag;
    status[STAT_STATE_LSB +: 2]    = state;
  end

  assign regs[ADDR_CTRL]   = {31'd0, ctrl_start};
  assign regs[ADDR_STATUS] = status;

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go) state_next = RUN;
      RUN: begin
        if (stop)          state_next = IDLE;
        else if (AES_DONE) state_next = DONE;
        else if (cnt_hit)  state_next = DONE;
      end
      DONE:    if (stop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    AES_START = (state != IDLE);
    capture   = (state == RUN) && !stop && AES_DONE;
    timed_out = (state == RUN) && !stop && !AES_DONE && cnt_hit;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      run_cnt      <= '0;
      ctrl_start   <= 1'b0;
      done_flag    <= 1'b0;
      timeout_flag <= 1'b0;
      AVL_READDATA <= '0;
    end else begin
      run_cnt <= (state == RUN) ? run_cnt + 32'd1 : '0;
      if (ctrl_wr) ctrl_start <= AVL_WRITEDATA[0];
      if (state == IDLE && go) begin
        done_flag    <= 1'b0;
        timeout_flag <= 1'b0;
      end else if (state == RUN && stop) begin
        done_flag <= 1'b0;
      end else if (capture) begin
        done_flag <= 1'b1;
      end else if (timed_out) begin
        timeout_flag <= 1'b1;
      end
      // Registers update on this same edge, so a colliding write is not seen.
      if (AVL_CS && AVL_READ) AVL_READDATA <= regs[AVL_ADDR];
    end
  end

  assign AES_KEY     = {regs[ADDR_KEY0], regs[ADDR_KEY0+1], regs[ADDR_KEY0+2], regs[ADDR_KEY0+3]};
  assign AES_MSG_ENC = {regs[ADDR_MSG_ENC0], regs[ADDR_MSG_ENC0+1],
                        regs[ADDR_MSG_ENC0+2], regs[ADDR_MSG_ENC0+3]};
  assign EXPORT_DATA = {regs[ADDR_KEY0][31:16], regs[ADDR_KEY0+3][15:0]};

endmodule
